jtag_dr_sequencer: RTL and testbench

//  TCK-domain controller for the LM32 debug user data register behind the BSCAN TAP wrapper.

---
 rtl/jtag_dr_pkg.sv | 21 ++
 rtl/jtag_dr_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_jtag_dr_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/jtag_dr_pkg.sv
// Shared constants for the LM32 debug user-DR sequencer: FSM encodings,
// status-bit offsets (relative to DATA_WIDTH) and the NOP opcode.
package jtag_dr_pkg;

    localparam int unsigned PKG_DATA_WIDTH = 8;
    localparam int unsigned PKG_ADDR_WIDTH = 3;

    typedef logic [1:0] dr_state_t;

    localparam dr_state_t S_IDLE  = 2'd0;
    localparam dr_state_t S_SHIFT = 2'd1;
    localparam dr_state_t S_EXIT1 = 2'd2;

    // Status bits sit directly above the response payload in the captured frame.
    localparam int unsigned ST_RSP_FULL_OFS = 0;
    localparam int unsigned ST_BUSY_OFS     = 1;
    localparam int unsigned ST_OVR_OFS      = 2;

    localparam int unsigned OP_NOP = 0;

endpackage

// File: rtl/jtag_dr_sequencer.sv
// TCK-domain user-DR sequencer: frames capture/shift/exit1/update, checks the
// frame length, and exchanges commands/responses with the debug core.
module jtag_dr_sequencer
    import jtag_dr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PKG_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = PKG_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  jtag_tdi_i,
    output logic                  jtag_tdo_o,
    input  logic                  jtag_capture_i,
    input  logic                  jtag_shift_i,
    input  logic                  jtag_e1dr_i,
    input  logic                  jtag_update_i,
    input  logic                  jtag_reset_i,
    output logic [ADDR_WIDTH-1:0] cmd_addr_o,
    output logic [DATA_WIDTH-1:0] cmd_data_o,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    input  logic [DATA_WIDTH-1:0] rsp_data_i,
    input  logic                  rsp_valid_i,
    output logic                  rsp_ready_o
);

    localparam int unsigned DR_LEN      = ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned CNT_W       = $clog2(DR_LEN + 2);
    localparam int unsigned ST_RSP_FULL = DATA_WIDTH + ST_RSP_FULL_OFS;
    localparam int unsigned ST_BUSY     = DATA_WIDTH + ST_BUSY_OFS;
    localparam int unsigned ST_OVR      = DATA_WIDTH + ST_OVR_OFS;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DR_LEN + 1);

    dr_state_t             state_q,   state_d;
    logic [DR_LEN-1:0]     sr_q,      sr_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  cap_rsp_q, cap_rsp_d;

    logic [ADDR_WIDTH-1:0] cmd_addr_q,  cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_data_q,  cmd_data_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic                  overrun_q,   overrun_d;
    logic [DATA_WIDTH-1:0] rsp_buf_q,   rsp_buf_d;
    logic                  rsp_full_q,  rsp_full_d;

    logic [DR_LEN-1:0]     status;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] frame_addr;
    logic [DATA_WIDTH-1:0] frame_data;

    always_comb begin
        status                  = '0;
        status[DATA_WIDTH-1:0]  = rsp_buf_q;
        status[ST_RSP_FULL]     = rsp_full_q;
        status[ST_BUSY]         = cmd_valid_q;
        status[ST_OVR]          = overrun_q;
    end

    assign frame_addr = sr_q[DR_LEN-1:DATA_WIDTH];
    assign frame_data = sr_q[DATA_WIDTH-1:0];

    // Frame sequencer: shift register, bit counter and TAP-phase FSM.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        cap_rsp_d = cap_rsp_q;
        commit    = 1'b0;
        if (jtag_reset_i) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (jtag_capture_i) begin
                        state_d   = S_SHIFT;
                        sr_d      = status;
                        bit_cnt_d = '0;
                        cap_rsp_d = rsp_full_q;
                    end
                end
                S_SHIFT: begin
                    if (jtag_shift_i) begin
                        sr_d = {jtag_tdi_i, sr_q[DR_LEN-1:1]};
                        if (bit_cnt_q != CNT_SAT) begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    if (jtag_e1dr_i) begin
                        state_d = S_EXIT1;
                    end
                end
                S_EXIT1: begin
                    if (jtag_update_i) begin
                        state_d = S_IDLE;
                        commit  = (bit_cnt_q == CNT_FULL);
                    end else if (jtag_capture_i) begin
                        // Pause/re-enter: the partial frame is discarded and status re-sampled.
                        state_d   = S_SHIFT;
                        sr_d      = status;
                        bit_cnt_d = '0;
                        cap_rsp_d = rsp_full_q;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            cap_rsp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            cap_rsp_q <= cap_rsp_d;
        end
    end

    // Command/response handshake registers.
    always_comb begin
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = cmd_valid_q;
        overrun_d   = overrun_q;
        rsp_buf_d   = rsp_buf_q;
        rsp_full_d  = rsp_full_q;

        if (cmd_valid_q && cmd_ready_i) begin
            cmd_valid_d = 1'b0;
        end
        if (commit && (frame_addr != ADDR_WIDTH'(OP_NOP))) begin
            if (!cmd_valid_q || cmd_ready_i) begin
                cmd_addr_d  = frame_addr;
                cmd_data_d  = frame_data;
                cmd_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        // An ack only happens when rsp_full was set at capture and is still set, so
        // it can never coincide with a response load below.
        if (commit && cap_rsp_q) begin
            rsp_full_d = 1'b0;
        end
        if (rsp_valid_i && !rsp_full_q) begin
            rsp_buf_d  = rsp_data_i;
            rsp_full_d = 1'b1;
        end

        if (jtag_reset_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            rsp_buf_q   <= '0;
            rsp_full_q  <= 1'b0;
        end else begin
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            overrun_q   <= overrun_d;
            rsp_buf_q   <= rsp_buf_d;
            rsp_full_q  <= rsp_full_d;
        end
    end

    assign jtag_tdo_o  = sr_q[0];
    assign cmd_addr_o  = cmd_addr_q;
    assign cmd_data_o  = cmd_data_q;
    assign cmd_valid_o = cmd_valid_q;
    assign rsp_ready_o = ~rsp_full_q;

endmodule

// File: tb/tb_jtag_dr_sequencer.sv
// Directed bench for jtag_dr_sequencer (DATA_WIDTH=8, ADDR_WIDTH=3, 11-bit frames).
module tb_jtag_dr_sequencer;

    logic       clk;
    logic       rst;
    logic       tdi;
    logic       tdo;
    logic       capture;
    logic       shift;
    logic       e1dr;
    logic       update;
    logic       treset;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_ready;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    jtag_dr_sequencer #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .jtag_tdi_i     (tdi),
        .jtag_tdo_o     (tdo),
        .jtag_capture_i (capture),
        .jtag_shift_i   (shift),
        .jtag_e1dr_i    (e1dr),
        .jtag_update_i  (update),
        .jtag_reset_i   (treset),
        .cmd_addr_o     (cmd_addr),
        .cmd_data_o     (cmd_data),
        .cmd_valid_o    (cmd_valid),
        .cmd_ready_i    (cmd_ready),
        .rsp_data_i     (rsp_data),
        .rsp_valid_i    (rsp_valid),
        .rsp_ready_o    (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_capture();
        capture = 1'b1; step(); capture = 1'b0;
    endtask

    task automatic do_e1dr();
        e1dr = 1'b1; step(); e1dr = 1'b0;
    endtask

    task automatic do_update();
        update = 1'b1; step(); update = 1'b0;
    endtask

    task automatic shift_n(input logic [15:0] bits, input int unsigned n, output logic [15:0] seen);
        seen  = '0;
        shift = 1'b1;
        for (int unsigned i = 0; i < n; i++) begin
            tdi     = bits[i];
            seen[i] = tdo;
            step();
        end
        shift = 1'b0;
        tdi   = 1'b0;
    endtask

    task automatic run_frame(input logic [10:0] f, output logic [15:0] st);
        do_capture();
        shift_n({5'b0, f}, 11, st);
        do_e1dr();
        do_update();
    endtask

    task automatic give_rsp(input logic [7:0] d);
        rsp_data = d; rsp_valid = 1'b1; step(); rsp_valid = 1'b0;
    endtask

    task automatic retire_cmd();
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
    endtask

    logic [15:0] st;

    initial begin
        rst = 1'b1; tdi = 1'b0; capture = 1'b0; shift = 1'b0; e1dr = 1'b0;
        update = 1'b0; treset = 1'b0; cmd_ready = 1'b0; rsp_data = '0; rsp_valid = 1'b0;
        step(); step();
        chk("rst_tdo", {15'b0, tdo}, 16'h0);
        chk("rst_valid", {15'b0, cmd_valid}, 16'h0);
        chk("rst_addr_data", {5'b0, cmd_addr, cmd_data}, 16'h0);
        chk("rst_rsp_ready", {15'b0, rsp_ready}, 16'h1);
        rst = 1'b0;
        step();

        // 1: basic command frame
        run_frame(11'h2A5, st);
        chk("t1_tdo_stream", st, 16'h000);
        chk("t1_valid", {15'b0, cmd_valid}, 16'h1);
        chk("t1_addr", {13'b0, cmd_addr}, 16'h2);
        chk("t1_data", {8'b0, cmd_data}, 16'hA5);
        retire_cmd();
        chk("t1_retired", {15'b0, cmd_valid}, 16'h0);

        // 2: response readback and ack by NOP frame
        give_rsp(8'h3C);
        chk("t2_rsp_ready_full", {15'b0, rsp_ready}, 16'h0);
        run_frame(11'h0FF, st);
        chk("t2_status1", st, 16'h13C);
        chk("t2_rsp_acked", {15'b0, rsp_ready}, 16'h1);
        chk("t2_nop_no_cmd", {15'b0, cmd_valid}, 16'h0);
        run_frame(11'h000, st);
        chk("t2_status2", st, 16'h03C);

        // 3: overrun with consumer stalled, cleared by TAP reset
        run_frame(11'h111, st);
        chk("t3_status_a", st, 16'h03C);
        run_frame(11'h322, st);
        chk("t3_status_b", st, 16'h23C);
        chk("t3_held", {4'b0, cmd_valid, cmd_addr, cmd_data}, 16'h0911);
        run_frame(11'h000, st);
        chk("t3_overrun_seen", st, 16'h63C);
        treset = 1'b1; step(); treset = 1'b0;
        run_frame(11'h000, st);
        chk("t3_overrun_cleared", st, 16'h23C);
        retire_cmd();
        chk("t3_retired", {15'b0, cmd_valid}, 16'h0);

        // 4: short and long frames never commit nor ack
        give_rsp(8'h5A);
        do_capture();
        shift_n(16'h04FF, 10, st);
        do_e1dr();
        do_update();
        chk("t4_short_status", st, 16'h015A);
        chk("t4_short_no_cmd", {15'b0, cmd_valid}, 16'h0);
        chk("t4_short_no_ack", {15'b0, rsp_ready}, 16'h0);
        do_capture();
        shift_n(16'h04FF, 12, st);
        do_e1dr();
        do_update();
        chk("t4_long_status", {5'b0, st[10:0]}, 16'h015A);
        chk("t4_long_no_cmd", {15'b0, cmd_valid}, 16'h0);
        chk("t4_long_no_ack", {15'b0, rsp_ready}, 16'h0);

        // 5: aborted partial frame then re-capture
        do_capture();
        shift_n(16'h001F, 5, st);
        do_e1dr();
        chk("t5_partial_no_cmd", {15'b0, cmd_valid}, 16'h0);
        do_capture();
        shift_n(16'h07C3, 11, st);
        do_e1dr();
        do_update();
        chk("t5_status", st, 16'h015A);
        chk("t5_cmd", {4'b0, cmd_valid, cmd_addr, cmd_data}, 16'h0FC3);
        chk("t5_rsp_acked", {15'b0, rsp_ready}, 16'h1);
        retire_cmd();
        chk("t5_single_cmd", {15'b0, cmd_valid}, 16'h0);
        do_update();
        chk("idle_update_ignored", {15'b0, cmd_valid}, 16'h0);

        // 6: async reset mid-shift
        run_frame(11'h566, st);
        chk("t6_status", st, 16'h005A);
        chk("t6_cmd", {4'b0, cmd_valid, cmd_addr, cmd_data}, 16'h0D66);
        give_rsp(8'h99);
        do_capture();
        shift = 1'b1;
        tdi   = 1'b1;
        for (int k = 0; k < 4; k++) step();
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_tdo", {15'b0, tdo}, 16'h0);
        chk("t6_rst_cmd", {4'b0, cmd_valid, cmd_addr, cmd_data}, 16'h0);
        chk("t6_rst_rsp_ready", {15'b0, rsp_ready}, 16'h1);
        shift = 1'b0;
        tdi   = 1'b0;
        step();
        rst = 1'b0;
        step();
        run_frame(11'h4AB, st);
        chk("t6_post_status", st, 16'h000);
        chk("t6_post_cmd", {4'b0, cmd_valid, cmd_addr, cmd_data}, 16'h0CAB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
